// File: rtl/mape_pkg.sv
// mape_pkg: shared wr_mode codes and scheduler state encoding
// for the mape front-end scheduler and its arbiter.
package mape_pkg;

  localparam logic [1:0] MODE_SEL  = 2'b00;
  localparam logic [1:0] MODE_CTRL = 2'b01;
  localparam logic [1:0] MODE_G1   = 2'b10;
  localparam logic [1:0] MODE_G2   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_CTRL = 3'd1,
    ST_LD_G1   = 3'd2,
    ST_LD_G2   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mape_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr.
// Ports: req, ptr, en in; one-hot gnt and binary gnt_idx out.
module rr_arbiter
  import mape_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  if (N == 1) begin : g_single
    assign gnt     = req & {N{en}};
    assign gnt_idx = '0;
  end else begin : g_multi
    logic [PW-1:0] idx;
    logic          found;

    function automatic int wrap(input int p, input int o);
      int s;
      s = p + o;
      return (s >= N) ? s - N : s;
    endfunction

    // Scan starts one past the last winner so it gets lowest priority.
    always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      found   = 1'b0;
      for (int off = 1; off <= N; off++) begin
        idx = PW'(wrap(int'(ptr), off));
        if (en && !found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mape_sched.sv
// mape_sched: round-robin job scheduler that loads mape, waits for done
// or timeout, and returns a tagged result on a valid/ready channel.
module mape_sched
  import mape_pkg::*;
#(
  parameter int WORD_SZ = 64,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WORD_SZ-1:0] req_ctrl,
  input  logic [NUM_REQ*WORD_SZ-1:0] req_g1,
  input  logic [NUM_REQ*WORD_SZ-1:0] req_g2,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WORD_SZ-1:0]         rsp_data,
  output logic                       rsp_timeout,
  output logic [1:0]                 mape_wr_mode,
  output logic [WORD_SZ-1:0]         mape_data_in,
  input  logic [WORD_SZ-1:0]         mape_data_out,
  input  logic                       mape_done,
  output logic                       busy
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [WORD_SZ-1:0] ctrl_q;
  logic [WORD_SZ-1:0] g1_q;
  logic [WORD_SZ-1:0] g2_q;
  logic [ID_W-1:0]    id_q;
  logic [15:0]        cnt;
  logic               arb_en;
  logic               accept;
  logic               done_hit;
  logic               to_hit;
  logic               rsp_fire;

  // Gate with rst_n so req_ready stays low while reset is held.
  assign arb_en = (state == ST_IDLE) && rst_n;

  rr_arbiter #(
    .N (NUM_REQ),
    .PW(PW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign busy      = (state != ST_IDLE);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Done has priority over a coinciding timeout.
  assign done_hit = (state == ST_WAIT) && mape_done;
  assign to_hit   = (state == ST_WAIT) && !mape_done
                 && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    mape_wr_mode = MODE_SEL;
    mape_data_in = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_LD_CTRL;
      end
      ST_LD_CTRL: begin
        mape_wr_mode = MODE_CTRL;
        mape_data_in = ctrl_q;
        state_nx     = ST_LD_G1;
      end
      ST_LD_G1: begin
        mape_wr_mode = MODE_G1;
        mape_data_in = g1_q;
        state_nx     = ST_LD_G2;
      end
      ST_LD_G2: begin
        mape_wr_mode = MODE_G2;
        mape_data_in = g2_q;
        state_nx     = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit || to_hit) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= PW'(NUM_REQ - 1);
      id_q        <= '0;
      ctrl_q      <= '0;
      g1_q        <= '0;
      g2_q        <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        ptr    <= gnt_idx;
        id_q   <= ID_W'(gnt_idx);
        ctrl_q <= req_ctrl[int'(gnt_idx)*WORD_SZ +: WORD_SZ];
        g1_q   <= req_g1[int'(gnt_idx)*WORD_SZ +: WORD_SZ];
        g2_q   <= req_g2[int'(gnt_idx)*WORD_SZ +: WORD_SZ];
      end
      if (state == ST_WAIT) begin
        cnt <= cnt + 16'd1;
        if (done_hit) begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_data    <= mape_data_out;
          rsp_timeout <= 1'b0;
        end else if (to_hit) begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_data    <= '0;
          rsp_timeout <= 1'b1;
        end
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mape_sched.sv
// tb_mape_sched: randomized self-checking bench for mape_sched
// with a job-level reference model (grant order, latency, result).
module tb_mape_sched;

  localparam int W  = 64;
  localparam int NR = 3;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int OW = NR + 1 + IW + W + 1 + 2 + W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_ctrl;
  logic [NR*W-1:0]   req_g1;
  logic [NR*W-1:0]   req_g2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_timeout;
  logic [1:0]        mape_wr_mode;
  logic [W-1:0]      mape_data_in;
  logic [W-1:0]      mape_data_out;
  logic              mape_done;
  logic              busy;

  mape_sched #(
    .WORD_SZ(W),
    .NUM_REQ(NR),
    .ID_W   (IW),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctrl     (req_ctrl),
    .req_g1       (req_g1),
    .req_g2       (req_g2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .mape_wr_mode (mape_wr_mode),
    .mape_data_in (mape_data_in),
    .mape_data_out(mape_data_out),
    .mape_done    (mape_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int last;

  logic [W-1:0] ctrl_a [NR];
  logic [W-1:0] g1_a   [NR];
  logic [W-1:0] g2_a   [NR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: winner is the first valid channel after the last winner.
  function automatic int model_grant(input logic [NR-1:0] v,
                                     input int from);
    for (int off = 1; off <= NR; off++) begin
      int c;
      c = (from + off) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    if (g < 0) return '0;
    return NR'(1) << g;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
            mape_wr_mode, mape_data_in, busy};
  endfunction

  task automatic load_payloads();
    for (int i = 0; i < NR; i++) begin
      ctrl_a[i] = {$urandom, $urandom};
      g1_a[i]   = {$urandom, $urandom};
      g2_a[i]   = {$urandom, $urandom};
      req_ctrl[i*W +: W] = ctrl_a[i];
      req_g1[i*W +: W]   = g1_a[i];
      req_g2[i*W +: W]   = g2_a[i];
    end
  endtask

  // One full job: grant, three loads, wait, response, optional stall.
  task automatic run_job(input logic [NR-1:0] vmask,
                         input int done_at, input int hold);
    int g;
    int k;
    int nxt;
    bit fin;
    bit quiet;
    logic [W-1:0] dout;
    logic [W-1:0] exp_data;
    logic         exp_to;
    load_payloads();
    rsp_ready = 1'b0;
    mape_done = 1'b0;
    req_valid = vmask;
    #1;
    g = model_grant(vmask, last);
    checks++;
    if (req_ready !== onehot(g))
      $display("FAIL grant: req_ready=%b want %b", req_ready, onehot(g));
    else passes++;
    tick();
    req_valid = '0;
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b01, ctrl_a[g]})
      $display("FAIL ld_ctrl: mode=%b data=%h want 01 %h",
               mape_wr_mode, mape_data_in, ctrl_a[g]);
    else passes++;
    tick();
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b10, g1_a[g]})
      $display("FAIL ld_g1: mode=%b data=%h want 10 %h",
               mape_wr_mode, mape_data_in, g1_a[g]);
    else passes++;
    tick();
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b11, g2_a[g]})
      $display("FAIL ld_g2: mode=%b data=%h want 11 %h",
               mape_wr_mode, mape_data_in, g2_a[g]);
    else passes++;
    tick();
    k = 0;
    fin = 1'b0;
    quiet = 1'b1;
    exp_data = '0;
    exp_to = 1'b0;
    while (!fin && k < TO + 2) begin
      dout = {$urandom, $urandom};
      mape_data_out = dout;
      mape_done = (k == done_at);
      #1;
      if (rsp_valid || mape_wr_mode != 2'b00 || mape_data_in != '0)
        quiet = 1'b0;
      if (k == done_at) begin
        exp_data = dout;
        exp_to = 1'b0;
        fin = 1'b1;
      end else if (k == TO - 1) begin
        exp_data = '0;
        exp_to = 1'b1;
        fin = 1'b1;
      end
      tick();
      k++;
    end
    mape_done = 1'b0;
    mape_data_out = {$urandom, $urandom};
    checks++;
    if (!quiet)
      $display("FAIL wait_quiet: early rsp or wr_mode activity in WAIT");
    else passes++;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_timeout} !==
        {1'b1, IW'(g), exp_data, exp_to})
      $display("FAIL rsp: v=%b id=%0d data=%h to=%b want 1 %0d %h %b",
               rsp_valid, rsp_id, rsp_data, rsp_timeout,
               g, exp_data, exp_to);
    else passes++;
    for (int h = 0; h < hold; h++) begin
      req_valid = '1;
      mape_done = 1'b1;
      #1;
      checks++;
      if ({req_ready, mape_wr_mode, rsp_valid, rsp_id, rsp_data,
           rsp_timeout} !==
          {NR'(0), 2'b00, 1'b1, IW'(g), exp_data, exp_to})
        $display("FAIL hold: rdy=%b mode=%b v=%b id=%0d data=%h to=%b",
                 req_ready, mape_wr_mode, rsp_valid, rsp_id,
                 rsp_data, rsp_timeout);
      else passes++;
      tick();
    end
    mape_done = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    nxt = model_grant('1, g);
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, onehot(nxt)})
      $display("FAIL post_hs: v=%b rdy=%b want 0 %b",
               rsp_valid, req_ready, onehot(nxt));
    else passes++;
    req_valid = '0;
    #1;
    last = g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    mape_done = 1'b0;
    mape_data_out = '0;
    load_payloads();
    #3;
    checks++;
    if (outs() !== '0)
      $display("FAIL reset_async: outs=%h want 0", outs());
    else passes++;
    tick();
    tick();
    checks++;
    if (outs() !== '0)
      $display("FAIL reset_hold: outs=%h want 0", outs());
    else passes++;
    req_valid = '0;
    rst_n = 1'b1;
    last = NR - 1;
    tick();
    checks++;
    if (outs() !== '0)
      $display("FAIL reset_idle: outs=%h want 0", outs());
    else passes++;
  endtask

  task automatic test_single();
    load_payloads();
    ctrl_a[0] = 64'h1;
    g1_a[0]   = 64'hAAAA;
    g2_a[0]   = 64'h5555;
    req_ctrl[0 +: W] = ctrl_a[0];
    req_g1[0 +: W]   = g1_a[0];
    req_g2[0 +: W]   = g2_a[0];
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001)
      $display("FAIL single_c0: req_ready=%b want 001", req_ready);
    else passes++;
    tick();
    req_valid = '0;
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b01, 64'h1})
      $display("FAIL single_c1: %b %h", mape_wr_mode, mape_data_in);
    else passes++;
    tick();
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b10, 64'hAAAA})
      $display("FAIL single_c2: %b %h", mape_wr_mode, mape_data_in);
    else passes++;
    tick();
    checks++;
    if ({mape_wr_mode, mape_data_in} !== {2'b11, 64'h5555})
      $display("FAIL single_c3: %b %h", mape_wr_mode, mape_data_in);
    else passes++;
    tick();
    checks++;
    if ({mape_wr_mode, mape_data_in, busy} !== {2'b00, 64'h0, 1'b1})
      $display("FAIL single_c4: %b %h busy=%b",
               mape_wr_mode, mape_data_in, busy);
    else passes++;
    tick();
    tick();
    mape_done = 1'b1;
    mape_data_out = 64'hBEEF;
    #1;
    checks++;
    if (rsp_valid !== 1'b0)
      $display("FAIL single_c6: rsp_valid=%b want 0", rsp_valid);
    else passes++;
    tick();
    mape_done = 1'b0;
    mape_data_out = '0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_timeout} !==
        {1'b1, 2'd0, 64'hBEEF, 1'b0})
      $display("FAIL single_c7: v=%b id=%0d data=%h to=%b",
               rsp_valid, rsp_id, rsp_data, rsp_timeout);
    else passes++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL single_done: v=%b busy=%b", rsp_valid, busy);
    else passes++;
    last = 0;
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int j = 0; j < 4; j++) run_job(3'b011, 0, 0);
  endtask

  task automatic test_backpressure();
    run_job(3'b111, 1, 10);
  endtask

  task automatic test_timeout();
    run_job(3'b100, TO, 0);
    run_job(3'b010, TO, 2);
  endtask

  task automatic test_collision();
    run_job(3'b001, TO - 1, 0);
  endtask

  task automatic test_reset_mid_wait();
    bit idle_ok;
    load_payloads();
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_ready !== onehot(model_grant(3'b010, last)))
      $display("FAIL rmw_grant: req_ready=%b", req_ready);
    else passes++;
    tick();
    req_valid = '0;
    for (int c = 1; c <= 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== '0)
      $display("FAIL rmw_async: outs=%h want 0", outs());
    else passes++;
    tick();
    rst_n = 1'b1;
    last = NR - 1;
    idle_ok = 1'b1;
    mape_done = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid || busy) idle_ok = 1'b0;
    end
    mape_done = 1'b0;
    checks++;
    if (!idle_ok)
      $display("FAIL rmw_no_rsp: response or busy after reset");
    else passes++;
    run_job(3'b111, 0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++)
      run_job(NR'($urandom_range(1, 7)), $urandom_range(0, TO),
              $urandom_range(0, 3));
  endtask

  initial begin
    req_ctrl = '0;
    req_g1 = '0;
    req_g2 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mape_sched.md
Name: mape_sched

Overview:
- Front-end scheduler for the mape selection datapath.
- Arbitrates round-robin among NUM_REQ requester channels. Each channel offers one job: a control word plus two genomes.
- Sequences the granted job into mape through its wr_mode/data_in load protocol, then starts selection and waits for mape done (bounded by a timeout).
- Returns the mape result, tagged with the requester id, on a valid/ready response channel.

Parameters:
- WORD_SZ, 64, width of control word, genomes and result; matches mape.
- NUM_REQ, 2, number of requester channels (2..8).
- ID_W, 1, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 255, maximum WAIT cycles before a job is aborted (1..65535).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-channel job valid.
- req_ready  out  NUM_REQ  per-channel accept; one-hot or zero.
- req_ctrl  in  NUM_REQ*WORD_SZ  flattened control words; channel i occupies bits [i*WORD_SZ +: WORD_SZ].
- req_g1  in  NUM_REQ*WORD_SZ  flattened genome1.
- req_g2  in  NUM_REQ*WORD_SZ  flattened genome2.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  WORD_SZ  captured mape data_out.
- rsp_timeout  out  1  job aborted by timeout; rsp_data is 0 when set.
- mape_wr_mode  out  2  drives mape wr_mode.
- mape_data_in  out  WORD_SZ  drives mape data_in.
- mape_data_out  in  WORD_SZ  mape result.
- mape_done  in  1  mape selection complete.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs are 0: mape_wr_mode=2'b00, mape_data_in=0, rsp_*=0, req_ready=0, busy=0.
  - Round-robin pointer goes to NUM_REQ-1, so channel 0 has first priority.
  - Timeout counter goes to 0.
  - Reset mid-job drops the job silently; no response is issued.
- States: IDLE, LD_CTRL, LD_G1, LD_G2, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the arbiter grants the first valid channel after the pointer (wrapping).
  - req_ready[grant] is asserted combinationally in the same cycle.
  - The job words and grant id are registered, the pointer updates to grant, and the next state is LD_CTRL.
  - req_ready is 0 in every other state.
- LD_CTRL: exactly one cycle; mape_wr_mode=01, mape_data_in=ctrl. Next state LD_G1.
- LD_G1: exactly one cycle; mape_wr_mode=10, mape_data_in=g1. Next state LD_G2.
- LD_G2: exactly one cycle; mape_wr_mode=11, mape_data_in=g2. Next state WAIT.
- WAIT:
  - mape_wr_mode=00 and mape_data_in=0; the timeout counter increments each cycle.
  - If mape_done is high, capture mape_data_out into rsp_data, set rsp_timeout=0, go to RESP.
  - Else if the counter reaches TIMEOUT, set rsp_data=0 and rsp_timeout=1, go to RESP.
  - If done and timeout coincide, done wins.
- mape_done is ignored outside WAIT.
- mape_wr_mode=00 and mape_data_in=0 in IDLE and RESP as well.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_timeout are held stable until rsp_ready.
  - On the rsp_valid&rsp_ready cycle: clear rsp_valid and the counter, go to IDLE.
  - A new grant can occur on the following cycle at the earliest.
- Latency: accept at cycle N; loads at N+1..N+3; WAIT from N+4. If done is high in the first WAIT cycle, rsp_valid rises at N+5.
- Requesters must hold payload stable while req_valid is high and not yet granted. A requester may drop valid before grant; the arbiter only considers the current cycle.
- NUM_REQ=1: the arbiter degenerates to always granting channel 0.

Decomposition:
- Package mape_pkg holds:
  - wr_mode constants MODE_SEL=2'b00, MODE_CTRL=2'b01, MODE_G1=2'b10, MODE_G2=2'b11;
  - the state encoding (3-bit) for IDLE/LD_CTRL/LD_G1/LD_G2/WAIT/RESP.
- Sub-module rr_arbiter (parameter N) takes req[N] and pointer, enable, and produces a one-hot grant plus a binary grant index. It is purely combinational; the pointer register stays in mape_sched.

Test Plan:
- Single job, ch0: ctrl=0x1, g1=0xAAAA, g2=0x5555 valid at cycle 0.
  - Expect: req_ready[0] at cycle 0; wr_mode 01/10/11 with matching data_in at cycles 1/2/3; 00 at cycle 4.
  - Stimulus: mape_done=1 with data_out=0xBEEF at cycle 6.
  - Expect: rsp_valid at cycle 7, rsp_id=0, rsp_data=0xBEEF, rsp_timeout=0.
- Round-robin: ch0 and ch1 both valid continuously for 4 jobs, done 1 cycle into WAIT. Expect grant order 0,1,0,1 and rsp_id sequence 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP.
  - Expect rsp_* stable, req_ready=0 throughout, and no wr_mode activity.
  - Release rsp_ready; expect the next grant one cycle after the handshake.
- Timeout: TIMEOUT=8 with mape_done never asserted. Expect rsp_valid with rsp_timeout=1 and rsp_data=0, exactly 8 cycles after WAIT entry.
- Done/timeout collision: done asserted on the cycle the counter hits TIMEOUT. Expect rsp_timeout=0 with data captured.
- Reset mid-WAIT: pull rst_n low at cycle 5 of a job. Expect all outputs 0 immediately (async) and no response. After release, ch0 has priority again.
